bnn_operand_streamer: RTL and testbench

Front-end sequencer for a binary neuron stage. It holds a DEPTH-entry weight memory loaded over a configuration port. For each frame it clears the downstream XNOR/accumulate/sign stage, then streams input bytes accepted over a valid/ready handshake, each paired with its weight. It signals completion once the downstream sign output has settled.

---
 rtl/bnn_operand_streamer.sv | 146 ++++++++++++++
 tb/tb_bnn_operand_streamer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_operand_streamer.sv
// Operand sequencer for a binary neuron: clears the downstream accumulator, then pairs
// each accepted input byte with its stored weight and reports when the sign output settles.
module bnn_operand_streamer #(
    parameter int DEPTH        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [7:0]               cfg_wdata,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     nrn_clear,
    output logic                     nrn_ena,
    output logic [7:0]               nrn_input,
    output logic [7:0]               nrn_weight,
    output logic                     nrn_last,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [AW-1:0] IDX_LAST   = AW'(DEPTH - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_drain;
    logic          r_nrn_ena;
    logic          r_nrn_last;
    logic [7:0]    r_nrn_input;
    logic [7:0]    r_nrn_weight;
    logic          w_beat;
    logic          w_last_beat;

    assign w_beat      = in_valid && in_ready;
    assign w_last_beat = w_beat && (r_idx == IDX_LAST);

    // Pulse-type controls are masked by ena so a stalled beat or pulse is shown once, later.
    assign in_ready   = (r_state == S_STREAM) && ena;
    assign nrn_clear  = (r_state == S_CLEAR) && ena;
    assign done       = (r_state == S_DONE) && ena;
    assign nrn_ena    = r_nrn_ena && ena;
    assign nrn_last   = r_nrn_last && ena;
    assign busy       = (r_state != S_IDLE);
    assign nrn_input  = r_nrn_input;
    assign nrn_weight = r_nrn_weight;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; everything freezes while ena is low
    always_comb begin
        w_next_state = r_state;
        if (ena) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_next_state = S_CLEAR;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_CLEAR:  w_next_state = S_STREAM;
                S_STREAM: begin
                    if (w_last_beat) begin
                        w_next_state = S_DRAIN;
                    end else begin
                        w_next_state = S_STREAM;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_DRAIN;
                    end
                end
                S_DONE:   w_next_state = S_IDLE;
                default:  w_next_state = S_IDLE;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Weight memory: writable only while idle so a frame always sees a stable set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (ena && (r_state == S_IDLE) && cfg_we) begin
            r_mem[cfg_addr] <= cfg_wdata;
        end
    end

    // Beat index, drain counter and registered operand outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx        <= {AW{1'b0}};
            r_drain      <= {DW{1'b0}};
            r_nrn_ena    <= 1'b0;
            r_nrn_last   <= 1'b0;
            r_nrn_input  <= 8'h00;
            r_nrn_weight <= 8'h00;
        end else if (ena) begin
            if (r_state == S_CLEAR) begin
                r_idx <= {AW{1'b0}};
            end else if (w_beat) begin
                r_idx <= r_idx + AW'(1);
            end
            if (w_last_beat) begin
                r_drain <= {DW{1'b0}};
            end else if (r_state == S_DRAIN) begin
                r_drain <= r_drain + DW'(1);
            end
            r_nrn_ena  <= w_beat;
            r_nrn_last <= w_last_beat;
            if (w_beat) begin
                r_nrn_input  <= in_data;
                r_nrn_weight <= r_mem[r_idx];
            end
        end
    end
endmodule

// File: tb/tb_bnn_operand_streamer.sv
// Scoreboard bench for bnn_operand_streamer: accepted beats push expected (last,input,weight)
// from a bench-side weight model; presented beats pop and compare; frame timing is checked vs start.
module tb_bnn_operand_streamer;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n, ena, cfg_we, start, in_valid;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_wdata, in_data;
    logic       in_ready, nrn_clear, nrn_ena, nrn_last, busy, done;
    logic [7:0] nrn_input, nrn_weight;

    bnn_operand_streamer #(.DEPTH(DEPTH), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .nrn_clear(nrn_clear), .nrn_ena(nrn_ena),
        .nrn_input(nrn_input), .nrn_weight(nrn_weight), .nrn_last(nrn_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic [7:0]  tb_mem [DEPTH];
    logic [16:0] sb_q [$];
    int tb_idx, t0, rel_c;
    int clear_cnt, clear_cyc, done_cnt, done_cyc, last_cnt, last_cyc;
    int ena_cnt, first_ena_cyc, busy_cnt, beat_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Negedge monitor: event bookkeeping plus scoreboard pop/push
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (!ena)
                    check_val("ena_low_ctrl", {27'd0, in_ready, nrn_ena, nrn_clear, nrn_last, done}, 32'd0);
                if (nrn_clear) begin clear_cnt++; clear_cyc = cyc; end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (nrn_last) begin last_cnt++; last_cyc = cyc; end
                if (busy) busy_cnt++;
                if (nrn_ena) begin
                    if (ena_cnt == 0) first_ena_cyc = cyc;
                    ena_cnt++;
                    if (sb_q.size() == 0) begin
                        check_val("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        check_val("beat_last_in_wt", {15'd0, nrn_last, nrn_input, nrn_weight}, {15'd0, sb_q.pop_front()});
                    end
                end
                if (in_valid && in_ready) begin
                    sb_q.push_back({(tb_idx == DEPTH - 1), in_data, tb_mem[tb_idx[2:0]]});
                    tb_idx++;
                    beat_cnt++;
                end
            end
        end
    end

    task automatic write_w(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic start_frame();
        clear_cnt = 0; done_cnt = 0; last_cnt = 0; ena_cnt = 0; busy_cnt = 0; beat_cnt = 0;
        clear_cyc = -1; done_cyc = -1; last_cyc = -1; first_ena_cyc = -1;
        tb_idx = 0;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] base, input bit incr, input bit gaps);
        int   sent = 0;
        int   n = 0;
        bit   prev_beat = 1'b0;
        logic acc;
        while (sent < DEPTH && n < 200) begin
            in_valid = gaps ? !prev_beat : 1'b1;
            in_data  = incr ? base + 8'(sent) : base;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            prev_beat = acc;
            if (acc) sent++;
            n++;
        end
        in_valid = 1'b0;
        check_val("feed_complete", sent, DEPTH);
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("done_seen", (done_cnt > 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_timing(input string p, input int clr, input int lst, input int dn, input int fe);
        check_val({p, "_clear_cnt"}, clear_cnt, 1);
        check_val({p, "_clear_cyc"}, clear_cyc - t0, clr);
        check_val({p, "_done_cnt"}, done_cnt, 1);
        check_val({p, "_done_cyc"}, done_cyc - t0, dn);
        check_val({p, "_last_cnt"}, last_cnt, 1);
        check_val({p, "_last_cyc"}, last_cyc - t0, lst);
        check_val({p, "_ena_cnt"}, ena_cnt, DEPTH);
        check_val({p, "_first_ena"}, first_ena_cyc - t0, fe);
        check_val({p, "_busy_cycles"}, busy_cnt, dn);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 8'h00;
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", {8'd0, in_ready, nrn_clear, nrn_ena, nrn_last, busy, done, nrn_input, nrn_weight}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Frame A: all-ones back-to-back, with stray start pulses mid-frame
        for (int i = 0; i < DEPTH; i++) write_w(3'(i), 8'hFF);
        start_frame();
        fork
            feed(8'hFF, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                repeat (5) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        wait_done(40);
        check_timing("A", 1, 10, 12, 3);

        // Frame B: ramp weights, alternating bubbles, ignored write to mem[3] mid-stream
        for (int i = 0; i < DEPTH; i++) write_w(3'(i), 8'(i));
        start_frame();
        fork
            feed(8'hA0, 1'b1, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 8'h55;
                @(posedge clk);
                #1 cfg_we = 1'b0;
            end
        join
        wait_done(60);
        check_timing("B", 1, 17, 19, 3);

        // Frame C: ena dropped for 3 cycles in CLEAR, STREAM and DONE
        start_frame();
        fork
            feed(8'h10, 1'b1, 1'b0);
            begin
                for (int k = 0; k < 22; k++) begin
                    rel_c = cyc - t0;
                    ena = !((rel_c >= 1 && rel_c <= 3) || (rel_c >= 8 && rel_c <= 10) || (rel_c >= 18 && rel_c <= 20));
                    @(posedge clk); #1;
                end
                ena = 1'b1;
            end
        join
        wait_done(60);
        check_timing("C", 4, 16, 21, 6);

        // Frame D: synchronous reset after the 4th accepted beat
        start_frame();
        in_valid = 1'b1; in_data = 8'h77;
        for (int n = 0; n < 30 && beat_cnt < 4; n++) @(negedge clk);
        check_val("D_four_beats", beat_cnt, 4);
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'h00;
        @(negedge clk);
        check_val("D_rst_outs", {8'd0, in_ready, nrn_clear, nrn_ena, nrn_last, busy, done, nrn_input, nrn_weight}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check_val("D_no_done", done_cnt, 0);
        check_val("D_idle", busy, 1'b0);

        // Frame E: weights must read back as zero after the reset
        start_frame();
        feed(8'h3C, 1'b0, 1'b0);
        wait_done(40);
        check_timing("E", 1, 10, 12, 3);

        check_val("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always reaches its summary
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
